// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: field widths, opcodes, fetch FSM states.
// Pure declarations; no latency or flow control of its own.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 3;
  localparam int ADDR_W = 5;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    UPDATE = 2'd2,
    HALT   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// PC owner and fetch/issue sequencer; 3 cycles per instruction minimum (FETCH, ISSUE, UPDATE).
// Stalls in FETCH until mem_rd_valid and in ISSUE until instr_ready; outputs decode only from flops.
module instr_fetch_unit #(
  parameter int                DATA_W   = cpu_pkg::DATA_W,
  parameter int                OPC_W    = cpu_pkg::OPC_W,
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] operand,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              skip,
  input  logic              branch,
  input  logic              acc_zero,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              skip_q, skip_d;
  logic              branch_q, branch_d;
  logic              zero_q, zero_d;

  logic [OPC_W-1:0]  ir_opc;
  logic [ADDR_W-1:0] ir_opr;

  assign ir_opc = ir_q[DATA_W-1 -: OPC_W];
  assign ir_opr = ir_q[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      skip_q   <= 1'b0;
      branch_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      skip_q   <= skip_d;
      branch_q <= branch_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    skip_d   = skip_q;
    branch_d = branch_q;
    zero_d   = zero_q;

    unique case (state_q)
      FETCH: begin
        if (mem_rd_valid) begin
          ir_d    = mem_rd_data;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Controller decisions are only meaningful at the handshake, so freeze them here.
        if (instr_ready) begin
          skip_d   = skip;
          branch_d = branch;
          zero_d   = acc_zero;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        if (ir_opc == OPC_W'(OP_HLT)) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
          if (branch_q) begin
            pc_d = ir_opr;
          end else if (skip_q && zero_q) begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      HALT: begin
        if (resume) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign mem_rd_req  = (state_q == FETCH);
  assign mem_rd_addr = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign halted      = (state_q == HALT);
  assign opcode      = ir_opc;
  assign operand     = ir_opr;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural program memory and hand-driven controller.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_rd_req;
  logic [4:0] mem_rd_addr;
  logic       mem_rd_valid;
  logic [7:0] mem_rd_data;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic       instr_valid;
  logic       instr_ready;
  logic       skip;
  logic       branch;
  logic       acc_zero;
  logic       resume;
  logic [4:0] pc;
  logic       halted;

  logic [7:0] mem [0:31];
  int         mem_wait;
  int         wait_cnt;
  logic       spurious;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .opcode       (opcode),
    .operand      (operand),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .skip         (skip),
    .branch       (branch),
    .acc_zero     (acc_zero),
    .resume       (resume),
    .pc           (pc),
    .halted       (halted)
  );

  // Memory answers after mem_wait cycles of a held request; spurious injects a stray valid.
  assign mem_rd_valid = (mem_rd_req && (wait_cnt >= mem_wait)) || spurious;
  assign mem_rd_data  = mem[mem_rd_addr];

  always @(posedge clk) begin
    if (!mem_rd_req || mem_rd_valid) wait_cnt <= 0;
    else                             wait_cnt <= wait_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one non-halting instruction from its FETCH cycle (zero-wait memory) to the next FETCH.
  task automatic exec(input string tag, input logic [2:0] e_opc, input logic [4:0] e_opr,
                      input logic br, input logic sk, input logic az,
                      input logic [4:0] e_pc, input logic [4:0] e_next);
    branch      = br;
    skip        = sk;
    acc_zero    = az;
    instr_ready = 1'b1;
    tick();
    chk({tag, "_issue"}, {instr_valid, opcode, operand}, {1'b1, e_opc, e_opr});
    chk({tag, "_pc"}, pc, e_pc);
    tick();
    branch   = 1'b0;
    skip     = 1'b0;
    acc_zero = 1'b0;
    chk({tag, "_update"}, {instr_valid, mem_rd_req}, 2'b00);
    tick();
    chk({tag, "_next"}, {mem_rd_req, mem_rd_addr}, {1'b1, e_next});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0]  = 8'b010_00011;
    mem[1]  = 8'b111_10100;
    mem[20] = 8'b111_00100;
    mem[4]  = 8'b001_00000;
    mem[6]  = 8'b001_00000;
    mem[7]  = 8'b000_00000;
    mem[8]  = 8'b101_01010;
    mem[9]  = 8'b111_11111;
    mem[31] = 8'b110_00101;

    rst = 1'b1; instr_ready = 1'b0; skip = 1'b0; branch = 1'b0;
    acc_zero = 1'b0; resume = 1'b0; mem_wait = 0; spurious = 1'b0;
    tick();
    tick();
    chk("rst_pc", pc, 5'd0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_ir", {opcode, operand}, 8'h00);

    rst = 1'b0;
    chk("first_fetch", {mem_rd_req, mem_rd_addr}, {1'b1, 5'd0});

    exec("add0",    3'b010, 5'd3,  1'b0, 1'b0, 1'b0, 5'd1,  5'd1);
    exec("jmp1",    3'b111, 5'd20, 1'b1, 1'b0, 1'b0, 5'd2,  5'd20);
    exec("jmp_skp", 3'b111, 5'd4,  1'b1, 1'b1, 1'b1, 5'd21, 5'd4);
    exec("skz_z1",  3'b001, 5'd0,  1'b0, 1'b1, 1'b1, 5'd5,  5'd6);
    exec("skz_z0",  3'b001, 5'd0,  1'b0, 1'b1, 1'b0, 5'd7,  5'd7);

    instr_ready = 1'b1;
    tick();
    chk("hlt_issue", {instr_valid, opcode, pc}, {1'b1, 3'b000, 5'd8});
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_hold", {halted, mem_rd_req, instr_valid, pc}, {3'b100, 5'd8});
      tick();
    end
    resume = 1'b1;
    mem_wait = 4;
    instr_ready = 1'b0;
    tick();
    resume = 1'b0;
    chk("resume_fetch", {halted, mem_rd_req, mem_rd_addr}, {2'b01, 5'd8});

    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_hold", {mem_rd_req, mem_rd_addr, pc, instr_valid}, {1'b1, 5'd8, 5'd8, 1'b0});
    end
    tick();
    chk("lda_issue", {instr_valid, opcode, operand, pc}, {1'b1, 3'b101, 5'd10, 5'd9});
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    chk("spur_ir", {instr_valid, opcode, operand, pc}, {1'b1, 3'b101, 5'd10, 5'd9});
    tick();
    chk("ready_late", {instr_valid, opcode, operand, pc}, {1'b1, 3'b101, 5'd10, 5'd9});
    instr_ready = 1'b1;
    mem_wait = 0;
    tick();
    chk("lda_update", instr_valid, 1'b0);
    tick();
    chk("lda_next", {mem_rd_req, mem_rd_addr, pc}, {1'b1, 5'd9, 5'd9});

    exec("jmp31",   3'b111, 5'd31, 1'b1, 1'b0, 1'b0, 5'd10, 5'd31);
    exec("sto_wrap", 3'b110, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0);

    instr_ready = 1'b0;
    tick();
    chk("pre_rst_issue", {instr_valid, opcode, pc}, {1'b1, 3'b010, 5'd1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_issue", {instr_valid, pc, halted}, {1'b0, 5'd0, 1'b0});
    chk("rst_refetch", {mem_rd_req, mem_rd_addr}, {1'b1, 5'd0});
    tick();
    chk("refetch_issue", {instr_valid, opcode, operand, pc}, {1'b1, 3'b010, 5'd3, 5'd1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
